// File: rtl/ins_loader.sv
// Instruction-memory program loader: takes a byte stream (header, data, checksum) over
// valid/ready, writes 16-bit words from address 0 and keeps the CPU in reset while loading.
module ins_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {StIdle, StHdr, StHi, StLo, StWr, StChk} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    wl_d      = wl_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHdr;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
          ptr_d   = '0;
          csum_d  = '0;
        end
      end
      StHdr: begin
        if (accept) begin
          // A zero header means a full memory image.
          count_d = (in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W + 1)'(in_data);
          csum_d  = csum_q ^ in_data;
          state_d = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          wr_data_d = {hi_q, in_data};
          wr_addr_d = ptr_q;
          csum_d    = csum_q ^ in_data;
          state_d   = StWr;
        end
      end
      StWr: begin
        ptr_d   = ptr_q + 1'b1;
        wl_d    = wl_q + 1'b1;
        state_d = (wl_d == count_q) ? StChk : StHi;
      end
      StChk: begin
        if (accept) begin
          state_d = StIdle;
          if (in_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            // Keep the CPU held so a corrupt image never executes.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StHdr) || (state_d == StHi) || (state_d == StLo) ||
                 (state_d == StChk);
    wr_en_d    = (state_d == StWr);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      count_q    <= '0;
      wl_q       <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      wl_q       <= wl_d;
      hi_q       <= hi_d;
      csum_q     <= csum_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: drivers push expected writes and load outcomes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ins_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  ins_loader #(.ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic done;
    logic err;
    logic hold;
    int   wl;
  } res_t;

  wr_t         exp_wr[$];
  res_t        exp_res[$];
  logic [15:0] words[$];
  int          compared = 0;
  int          mismatched = 0;

  // Monitor state
  logic        prev_busy = 1'b0;
  logic        prev_wr = 1'b0;
  logic [7:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      prev_wr   = 1'b0;
    end else begin
      if (wr_en) begin
        compared++;
        if (prev_wr) begin
          mismatched++;
          $display("FAIL wr_pulse: wr_en high two cycles in a row, required single pulse");
        end
        compared++;
        if (exp_wr.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: got %h@%h, required no write", wr_data, wr_addr);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            mismatched++;
            $display("FAIL write: got %h@%h, required %h@%h", wr_data, wr_addr, e.data, e.addr);
          end
        end
      end else begin
        compared++;
        if (wr_addr !== last_addr || wr_data !== last_data) begin
          mismatched++;
          $display("FAIL wr_hold: got %h@%h, required %h@%h", wr_data, wr_addr, last_data,
                   last_addr);
        end
      end
      if (!prev_busy && busy) begin
        compared++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words_loaded !== 9'd0) begin
          mismatched++;
          $display("FAIL load_start: hold=%b done=%b err=%b wl=%0d, required 1 0 0 0",
                   cpu_hold, done, err, words_loaded);
        end
      end
      if (prev_busy && !busy) begin
        compared++;
        if (exp_res.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_end: load ended, required no end");
        end else begin
          res_t r;
          r = exp_res.pop_front();
          if (done !== r.done || err !== r.err || cpu_hold !== r.hold ||
              int'(words_loaded) != r.wl) begin
            mismatched++;
            $display("FAIL outcome: done=%b err=%b hold=%b wl=%0d, required %b %b %b %0d",
                     done, err, cpu_hold, words_loaded, r.done, r.err, r.hold, r.wl);
          end
        end
      end
      prev_busy = busy;
      prev_wr   = wr_en;
    end
    last_addr = wr_addr;
    last_data = wr_data;
  end

  // Present one byte and wait (bounded) until it is consumed; in_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!in_ready) begin
      mismatched++;
      $display("FAIL byte_timeout: in_ready=0 after 50 cycles, required 1");
    end
    @(negedge clk);
  endtask

  // Stream the contents of 'words' as one load; hdr is the header byte actually sent.
  task automatic run_load(input logic [7:0] hdr, input logic [7:0] csum_flip, input int gap,
                          input bit start_mid, input bit overlap);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    res_t       r;
    cs = hdr;
    bytes.push_back(hdr);
    foreach (words[i]) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
      exp_wr.push_back('{addr: 8'(i), data: words[i]});
    end
    bytes.push_back(cs ^ csum_flip);
    r.done = (csum_flip == 8'h00);
    r.err  = (csum_flip != 8'h00);
    r.hold = (csum_flip != 8'h00);
    r.wl   = words.size();
    exp_res.push_back(r);
    if (overlap) begin
      in_valid = 1'b1;
      in_data  = hdr;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (bytes[i]) begin
      start = start_mid && (i == 3);
      send_byte(bytes[i], gap);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    compared++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, words_loaded} !== '0) begin
      mismatched++;
      $display("FAIL %s: rdy=%b wr=%b %h@%h hold=%b busy=%b done=%b err=%b wl=%0d, required 0",
               name, in_ready, wr_en, wr_data, wr_addr, cpu_hold, busy, done, err, words_loaded);
    end
  endtask

  initial begin
    logic [15:0] saved[$];
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic good load, then the same stream with a bad checksum, then good again.
    words = {16'h1234, 16'hABCD};
    run_load(8'h02, 8'h00, 0, 1'b0, 1'b0);
    run_load(8'h02, 8'h01, 0, 1'b0, 1'b0);
    run_load(8'h02, 8'h00, 0, 1'b0, 1'b0);

    // Full-size image via zero header.
    words = {};
    for (int i = 0; i < 256; i++) words.push_back({8'(i), ~8'(i)});
    run_load(8'h00, 8'h00, 0, 1'b0, 1'b0);

    // Random loads, each repeated with and without backpressure gaps.
    for (int k = 0; k < 6; k++) begin
      words = {};
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back(16'($urandom));
      saved = words;
      run_load(8'(words.size()), ($urandom_range(2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               40, 1'b0, 1'b0);
      words = saved;
      run_load(8'(words.size()), 8'h00, 0, 1'b0, 1'b0);
    end

    // Start pulses while busy and together with a valid byte in IDLE.
    words = {16'hC0DE, 16'hBEEF, 16'h0102};
    run_load(8'h03, 8'h00, 20, 1'b1, 1'b1);

    // Asynchronous reset while in HI after the first word has been written.
    exp_wr.push_back('{addr: 8'h00, data: 16'h1122});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    words = {16'h5566};
    run_load(8'h01, 8'h00, 0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    compared++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: %0d writes, %0d outcomes pending, required 0 0", exp_wr.size(),
               exp_res.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
- Program loader for the 16-bit single-cycle CPU.
- It is the write side of instruction memory, which the CPU otherwise only reads.
- It accepts a byte stream from a host over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0.
- It verifies an XOR checksum and holds the CPU in reset while a load is in progress.

Parameters:
ADDR_W, 8, instruction-memory address width; word count field is ADDR_W+1 bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader accepts byte this cycle (byte consumed when in_valid & in_ready)
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  write address
wr_data  output  16  instruction word {hi byte, lo byte}
cpu_hold  output  1  CPU reset request; CPU reset = reset | cpu_hold
busy  output  1  load in progress (state != IDLE)
done  output  1  sticky: last load completed with good checksum
err  output  1  sticky: last load failed checksum
words_loaded  output  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All outputs 0: in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, words_loaded.
  - Internal pointer, count, hi register and checksum cleared.
- Stream format: header byte N, then 2N data bytes (high byte first per word), then one checksum byte.
  - Word count = N, except N=0 means 2^ADDR_W (256 by default).
  - Checksum = XOR of the header byte and all data bytes.
- Outputs are registered; a byte accepted on edge k affects state from k+1.
- State IDLE:
  - in_ready=0, busy=0.
  - start=1 → HDR: busy=1, cpu_hold=1, done=0, err=0, words_loaded=0, ptr=0, checksum=0.
- State HDR:
  - in_ready=1.
  - On accept: count from the byte (0→256); checksum ^= byte → HI.
- State HI:
  - in_ready=1.
  - On accept: hi=byte, checksum ^= byte → LO.
- State LO:
  - in_ready=1.
  - On accept: wr_data={hi,byte}, wr_addr=ptr, checksum ^= byte → WR.
- State WR:
  - in_ready=0; wr_en=1 for exactly this cycle.
  - ptr increments, wrapping modulo 2^ADDR_W; words_loaded increments.
  - If the new words_loaded == count → CHK, else → HI.
- State CHK:
  - in_ready=1.
  - On accept, byte == checksum → IDLE with done=1 and cpu_hold=0.
  - On accept, mismatch → IDLE with err=1 and cpu_hold kept at 1; a corrupt program never runs. The hold clears only on the next successful load or reset.
- Throughput: at most one word per 3 cycles (HI, LO, WR) with in_valid held high.
- Handshake rules:
  - A byte is consumed only on a cycle with in_valid & in_ready.
  - When in_ready=0 (IDLE, WR), in_data is ignored and the host must hold it.
  - in_valid gaps stall the FSM in its current state with no side effects.
- Boundary conditions:
  - start while busy: ignored.
  - start and in_valid in the same IDLE cycle: the byte is not consumed.
  - 256-word load: last write at address 255; ptr wraps to 0; words_loaded=256.
  - wr_addr and wr_data hold their last values when wr_en=0.
  - Reset mid-load: immediate return to IDLE with all outputs 0; words already written remain in memory. The next start reloads from address 0.
  - done and err are never both 1.

Test Plan:
- start; bytes 02,12,34,AB,CD,42 → writes 0x1234@0 and 0xABCD@1, each with a one-cycle wr_en; done=1, err=0, words_loaded=2, cpu_hold falls the cycle after 0x42 is accepted.
- Same stream with checksum 43 → both writes still occur; err=1, done=0, cpu_hold stays 1. A following good load clears err and cpu_hold.
- Header 00, 512 bytes with word i = {i, ~i}, correct checksum → 256 writes at addresses 0..255; words_loaded=256; done=1; no write to any other address.
- Backpressure: random in_valid gaps, plus in_valid held high across WR cycles → every byte consumed exactly once; written words identical to the no-gap run; never two wr_en pulses without an intervening LO accept.
- Assert reset after the first word's WR and during the next HI → all outputs 0 in the same cycle (asynchronous). A new start and a 1-word stream (01,55,66,checksum 32) → 0x5566@0, done=1.
- Pulse start while busy, and pulse start with in_valid=1 in IDLE → neither pulse restarts the load; no byte is consumed before HDR; words_loaded is not reset mid-load.
